// File: rtl/branch_target_predictor.sv
// Fetch-stage BTB predictor with execute-stage resolution and training.
// Lookup and resolve paths are combinational; table and statistics
// update on the rising clock edge.
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_F,
  output logic        o_prediction,
  output logic [31:0] o_PCTargetF,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_jump,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush_D,
  output logic        o_flush_E,
  output logic [31:0] o_br_count,
  output logic [31:0] o_miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_cnt    [ENTRIES];
  logic             r_jmp    [ENTRIES];
  logic [31:0]      r_br_count;
  logic [31:0]      r_miss_count;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_f_hit;
  logic             w_pred;
  logic             w_u_hit;
  logic             w_res_en;
  logic             w_mis;
  logic             w_unused;

  assign w_f_idx  = i_pc_F[IDX_W+1:2];
  assign w_f_tag  = i_pc_F[31:IDX_W+2];
  assign w_u_idx  = i_upd_pc[IDX_W+1:2];
  assign w_u_tag  = i_upd_pc[31:IDX_W+2];
  assign w_unused = ^i_pc_F[1:0];

  // Fetch lookup: hit and taken-prediction from the current table contents
  always_comb begin
    w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_pred       = i_rst_n && w_f_hit && (r_jmp[w_f_idx] || r_cnt[w_f_idx][1]);
    o_prediction = w_pred;
    o_PCTargetF  = w_pred ? r_target[w_f_idx] : '0;
  end

  // Execute resolve: mispredict detection and redirect, forced to 0 when idle or in reset
  always_comb begin
    w_res_en      = i_upd_en && i_rst_n;
    w_mis         = w_res_en && ((i_upd_taken != i_upd_pred) ||
                                 (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    o_mispredict  = w_mis;
    o_flush_D     = w_mis;
    o_flush_E     = w_mis;
    o_redirect_pc = w_res_en ? (i_upd_taken ? i_upd_target : i_upd_pc + 32'd4) : '0;
    w_u_hit       = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  end

  // Table training: counter update on hit, allocation on taken miss
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
        r_jmp[i]    <= 1'b0;
      end
    end else if (i_upd_en) begin
      if (w_u_hit) begin
        if (i_upd_is_jump) begin
          r_jmp[w_u_idx]    <= 1'b1;
          r_cnt[w_u_idx]    <= 2'd3;
          r_target[w_u_idx] <= i_upd_target;
        end else if (i_upd_taken) begin
          if (r_cnt[w_u_idx] != 2'd3) r_cnt[w_u_idx] <= r_cnt[w_u_idx] + 2'd1;
          r_target[w_u_idx] <= i_upd_target;
        end else begin
          if (r_cnt[w_u_idx] != 2'd0) r_cnt[w_u_idx] <= r_cnt[w_u_idx] - 2'd1;
        end
      end else if (i_upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= i_upd_target;
        r_jmp[w_u_idx]    <= i_upd_is_jump;
        r_cnt[w_u_idx]    <= i_upd_is_jump ? 2'd3 : 2'd2;
      end
    end
  end

  // Saturating statistics counters for resolved branches and mispredicts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (i_upd_en && (r_br_count != '1)) r_br_count <= r_br_count + 32'd1;
      if (w_mis && (r_miss_count != '1))  r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_br_count   = r_br_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expected values are queued
// when stimulus is driven and popped when the outputs are sampled.
module tb_branch_target_predictor;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_pc_F;
  logic        o_prediction;
  logic [31:0] o_PCTargetF;
  logic        i_upd_en;
  logic [31:0] i_upd_pc;
  logic        i_upd_is_jump;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred;
  logic [31:0] i_upd_pred_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic        o_flush_D;
  logic        o_flush_E;
  logic [31:0] o_br_count;
  logic [31:0] o_miss_count;

  branch_target_predictor #(.ENTRIES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_F(i_pc_F),
    .o_prediction(o_prediction), .o_PCTargetF(o_PCTargetF),
    .i_upd_en(i_upd_en), .i_upd_pc(i_upd_pc), .i_upd_is_jump(i_upd_is_jump),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .i_upd_pred(i_upd_pred), .i_upd_pred_target(i_upd_pred_target),
    .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_flush_D(o_flush_D), .o_flush_E(o_flush_E),
    .o_br_count(o_br_count), .o_miss_count(o_miss_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_br = 0;
  int   exp_miss = 0;

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<queued value>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic ep, input logic [31:0] et);
    i_pc_F = pc;
    expect_v("pred", {31'b0, ep});
    expect_v("target", et);
    #1;
    check_v({31'b0, o_prediction});
    check_v(o_PCTargetF);
  endtask

  task automatic stats;
    expect_v("br_count", exp_br);
    expect_v("miss_count", exp_miss);
    check_v(o_br_count);
    check_v(o_miss_count);
  endtask

  // drives one resolve, checks the combinational outputs, then lets it commit
  task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                     input logic [31:0] tgt, input logic pred, input logic [31:0] pt,
                     input logic em, input logic [31:0] er);
    i_upd_en = 1'b1; i_upd_pc = pc; i_upd_is_jump = jump; i_upd_taken = taken;
    i_upd_target = tgt; i_upd_pred = pred; i_upd_pred_target = pt;
    expect_v("mispredict", {31'b0, em});
    expect_v("flush_D", {31'b0, em});
    expect_v("flush_E", {31'b0, em});
    expect_v("redirect", er);
    #1;
    check_v({31'b0, o_mispredict});
    check_v({31'b0, o_flush_D});
    check_v({31'b0, o_flush_E});
    check_v(o_redirect_pc);
    exp_br++;
    if (em) exp_miss++;
    @(posedge i_clk);
    #1;
    i_upd_en = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_pc_F = 32'h40; i_upd_en = 1'b1; i_upd_pc = 32'h40;
    i_upd_is_jump = 1'b0; i_upd_taken = 1'b1; i_upd_target = 32'h80;
    i_upd_pred = 1'b0; i_upd_pred_target = 32'h0;
    #2;
    // in reset with an update presented: everything reads 0
    expect_v("rst_mispredict", 32'h0);
    expect_v("rst_redirect", 32'h0);
    check_v({31'b0, o_mispredict});
    check_v(o_redirect_pc);
    @(posedge i_clk); #1;
    i_upd_en = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    stats();
    lookup(32'h40, 1'b0, 32'h0);

    // first taken resolve allocates weakly-taken
    upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup(32'h40, 1'b1, 32'h80);
    // train down: cnt 2->1->0, then stays at 0
    upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    lookup(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 32'h44);
    lookup(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 32'h44);
    lookup(32'h40, 1'b0, 32'h0);
    // one taken from 0 only reaches 1: still not-taken prediction
    upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup(32'h40, 1'b0, 32'h0);

    // aliasing: 0x440 shares index 0 and evicts 0x40
    upd(32'h440, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 32'h900);
    lookup(32'h40, 1'b0, 32'h0);
    lookup(32'h440, 1'b1, 32'h900);

    // JAL at 0x100 (also index 0)
    upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    lookup(32'h100, 1'b1, 32'h200);
    lookup(32'h440, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h204, 1'b1, 32'h200);
    lookup(32'h100, 1'b1, 32'h200);

    // same-cycle lookup and update at 0x40: old contents, new next cycle
    lookup(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup(32'h40, 1'b1, 32'h80);
    stats();

    // idle resolve outputs
    expect_v("idle_mispredict", 32'h0);
    expect_v("idle_redirect", 32'h0);
    check_v({31'b0, o_mispredict});
    check_v(o_redirect_pc);

    // reset mid-cycle with an update pending: immediate clear, update discarded
    i_upd_en = 1'b1; i_upd_pc = 32'h300; i_upd_taken = 1'b1; i_upd_target = 32'h500;
    i_upd_is_jump = 1'b0; i_upd_pred = 1'b0;
    #1;
    i_rst_n = 1'b0;
    #1;
    exp_br = 0;
    exp_miss = 0;
    stats();
    lookup(32'h40, 1'b0, 32'h0);
    expect_v("rst2_mispredict", 32'h0);
    check_v({31'b0, o_mispredict});
    @(posedge i_clk); #1;
    i_upd_en = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    lookup(32'h300, 1'b0, 32'h0);
    lookup(32'h100, 1'b0, 32'h0);

    // ten resolves, three mispredicted, none allocating
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 1)
        upd(32'h1000 + i * 4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 32'h1004 + i * 4);
      else
        upd(32'h1000 + i * 4, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1004 + i * 4);
    end
    stats();
    lookup(32'h1004, 1'b0, 32'h0);

    // redirect wraps at 32 bits
    upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
